// File: rtl/regfile_sb.sv
// Parametrised register file with two combinational read ports, one write port
// and a per-register pending-write scoreboard (busy bits) for operand stalls.
module regfile_sb #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2,
  output logic              ReadBusy1,
  output logic              ReadBusy2,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] ReserveRegister,
  input  logic              Reserve,
  output logic              ReserveGrant
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             wr_en;
  logic             rsv_busy;

  // Out-of-range addresses and the hard-wired zero register are never stored.
  function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
    return (int'(addr) < DEPTH) && !(ZERO_REG && (addr == '0));
  endfunction

  assign wr_en = RegWrite && addr_valid(WriteRegister);

  always_comb begin
    rsv_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ReserveRegister == ADDR_W'(i)) rsv_busy = busy_q[i];
    end
  end

  // Grant looks only at current busy state; a same-cycle write does not help.
  assign ReserveGrant = Reserve && addr_valid(ReserveRegister) && !rsv_busy;

  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en && (WriteRegister == ADDR_W'(i))) begin
        mem_d[i]  = WriteData;
        busy_d[i] = 1'b0;
      end
      // A new reservation overrides the clear from a same-cycle write.
      if (ReserveGrant && (ReserveRegister == ADDR_W'(i))) busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
    logic              busy;

    assign addr = (gi == 0) ? ReadRegister1 : ReadRegister2;

    always_comb begin
      data = '0;
      busy = 1'b0;
      if (addr_valid(addr)) begin
        // Bypass is suppressed in reset so every read returns zero there.
        if (BYPASS && Reset_n && RegWrite && (WriteRegister == addr)) begin
          data = WriteData;
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (addr == ADDR_W'(i)) begin
              data = mem_q[i];
              busy = busy_q[i];
            end
          end
        end
      end
    end
  end

  assign ReadData1 = g_rd[0].data;
  assign ReadData2 = g_rd[1].data;
  assign ReadBusy1 = g_rd[0].busy;
  assign ReadBusy2 = g_rd[1].busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a default instance (zero reg, bypass) and a 16x24
// instance without zero reg or bypass, both checked against array models.
module tb_regfile_sb;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;
  logic Reset_n;

  logic [4:0]  a_rr1, a_rr2, a_wr, a_rsv_reg;
  logic [31:0] a_rd1, a_rd2, a_wd;
  logic        a_rb1, a_rb2, a_we, a_rsv, a_grant;

  logic [4:0]  b_rr1, b_rr2, b_wr, b_rsv_reg;
  logic [15:0] b_rd1, b_rd2, b_wd;
  logic        b_rb1, b_rb2, b_we, b_rsv, b_grant;

  int vectors = 0;
  int miscompares = 0;

  regfile_sb dut_a (
    .Clk(Clk), .Reset_n(Reset_n),
    .ReadRegister1(a_rr1), .ReadRegister2(a_rr2),
    .ReadData1(a_rd1), .ReadData2(a_rd2),
    .ReadBusy1(a_rb1), .ReadBusy2(a_rb2),
    .WriteRegister(a_wr), .WriteData(a_wd), .RegWrite(a_we),
    .ReserveRegister(a_rsv_reg), .Reserve(a_rsv), .ReserveGrant(a_grant)
  );

  regfile_sb #(.WIDTH(16), .DEPTH(24), .ADDR_W(5), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n),
    .ReadRegister1(b_rr1), .ReadRegister2(b_rr2),
    .ReadData1(b_rd1), .ReadData2(b_rd2),
    .ReadBusy1(b_rb1), .ReadBusy2(b_rb2),
    .WriteRegister(b_wr), .WriteData(b_wd), .RegWrite(b_we),
    .ReserveRegister(b_rsv_reg), .Reserve(b_rsv), .ReserveGrant(b_grant)
  );

  // Reference state: what each register holds and whether it is reserved.
  logic [31:0] am_mem [32];
  logic        am_busy [32];
  logic [15:0] bm_mem [24];
  logic        bm_busy [24];

  function automatic bit a_ok(int a);
    return (a < 32) && (a != 0);
  endfunction

  function automatic bit b_ok(int a);
    return a < 24;
  endfunction

  function automatic logic [31:0] a_exp_data(int a);
    if (!a_ok(a) || !Reset_n) return 32'h0;
    if (a_we && int'(a_wr) == a) return a_wd;
    return am_mem[a];
  endfunction

  function automatic logic a_exp_busy(int a);
    if (!a_ok(a) || !Reset_n) return 1'b0;
    if (a_we && int'(a_wr) == a) return 1'b0;
    return am_busy[a];
  endfunction

  function automatic logic a_exp_grant();
    return a_rsv && a_ok(int'(a_rsv_reg)) && !am_busy[a_rsv_reg];
  endfunction

  function automatic logic [15:0] b_exp_data(int a);
    if (!b_ok(a) || !Reset_n) return 16'h0;
    return bm_mem[a];
  endfunction

  function automatic logic b_exp_busy(int a);
    if (!b_ok(a) || !Reset_n) return 1'b0;
    return bm_busy[a];
  endfunction

  function automatic logic b_exp_grant();
    if (!b_ok(int'(b_rsv_reg))) return 1'b0;
    return b_rsv && !bm_busy[b_rsv_reg];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) begin am_mem[i] = '0; am_busy[i] = 1'b0; end
    for (int i = 0; i < 24; i++) begin bm_mem[i] = '0; bm_busy[i] = 1'b0; end
  endtask

  task automatic idle();
    a_we = 1'b0; a_rsv = 1'b0; a_wr = '0; a_wd = '0; a_rsv_reg = '0;
    b_we = 1'b0; b_rsv = 1'b0; b_wr = '0; b_wd = '0; b_rsv_reg = '0;
  endtask

  // Advance one edge, applying the model's view of what that edge does.
  task automatic step();
    logic ga, gb;
    @(posedge Clk);
    if (Reset_n) begin
      ga = a_exp_grant();
      gb = b_exp_grant();
      if (a_we && a_ok(int'(a_wr))) begin am_mem[a_wr] = a_wd; am_busy[a_wr] = 1'b0; end
      if (ga) am_busy[a_rsv_reg] = 1'b1;
      if (b_we && b_ok(int'(b_wr))) begin bm_mem[b_wr] = b_wd; bm_busy[b_wr] = 1'b0; end
      if (gb) bm_busy[b_rsv_reg] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    clear_model();
    Reset_n = 1'b0;
    a_rr1 = 5'd5; a_rr2 = 5'd31; b_rr1 = 5'd5; b_rr2 = 5'd0;
    #12;
    vectors++;
    if (a_rd1 !== 32'h0 || a_rb2 !== 1'b0 || b_rd1 !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_initial: a_rd1=%h a_rb2=%b b_rd1=%h, required 0/0/0", a_rd1, a_rb2, b_rd1);
    end
    #2 Reset_n = 1'b1;
    step();
    // Load random contents and reservations, then reset mid-cycle.
    for (int i = 0; i < 32; i++) begin
      a_we = 1'b1; a_wr = 5'(i); a_wd = $urandom;
      a_rsv = i[0]; a_rsv_reg = 5'(31 - i);
      b_we = 1'b1; b_wr = 5'(i); b_wd = 16'($urandom);
      b_rsv = i[1]; b_rsv_reg = 5'(23 - (i % 24));
      step();
    end
    idle();
    #3 Reset_n = 1'b0;
    clear_model();
    a_we = 1'b1; a_wr = 5'd5; a_wd = 32'hCAFEF00D;
    b_we = 1'b1; b_wr = 5'd5; b_wd = 16'hF00D;
    a_rsv = 1'b1; a_rsv_reg = 5'd9;
    #1;
    vectors++;
    if (a_grant !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_grant: got %b, required 1", a_grant);
    end
    for (int i = 0; i < 32; i++) begin
      a_rr1 = 5'(i); a_rr2 = 5'(31 - i); b_rr1 = 5'(i); b_rr2 = 5'(31 - i);
      #1;
      vectors++;
      if (a_rd1 !== 32'h0 || a_rd2 !== 32'h0 || a_rb1 !== 1'b0 || a_rb2 !== 1'b0 ||
          b_rd1 !== 16'h0 || b_rd2 !== 16'h0 || b_rb1 !== 1'b0 || b_rb2 !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_sweep r%0d: a=%h/%h %b%b b=%h/%h %b%b, required all 0",
                 i, a_rd1, a_rd2, a_rb1, a_rb2, b_rd1, b_rd2, b_rb1, b_rb2);
      end
    end
    @(posedge Clk); #1;
    idle();
    #3 Reset_n = 1'b1;
    a_we = 1'b1; a_wr = 5'd4; a_wd = 32'h77;
    step();
    idle();
    a_rr1 = 5'd4; a_rr2 = 5'd5; b_rr1 = 5'd5; a_rsv_reg = 5'd9; a_rsv = 1'b1;
    #1;
    vectors++;
    if (a_rd1 !== 32'h77 || a_rd2 !== 32'h0 || b_rd1 !== 16'h0 || a_grant !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: r4=%h r5=%h b_r5=%h grant=%b, required 77/0/0/1",
               a_rd1, a_rd2, b_rd1, a_grant);
    end
    a_rsv = 1'b0;
  endtask

  task automatic test_write_read();
    idle();
    a_we = 1'b1; a_wr = 5'd5; a_wd = 32'hDEADBEEF;
    step();
    a_wr = 5'd31; a_wd = 32'h12345678;
    step();
    idle();
    a_rr1 = 5'd5; a_rr2 = 5'd31;
    #1;
    vectors++;
    if (a_rd1 !== 32'hDEADBEEF || a_rd2 !== 32'h12345678) begin
      miscompares++;
      $display("FAIL write_read: r5=%h r31=%h, required deadbeef/12345678", a_rd1, a_rd2);
    end
    a_we = 1'b1; a_wr = 5'd0; a_wd = 32'hFFFFFFFF; a_rr1 = 5'd0;
    #1;
    vectors++;
    if (a_rd1 !== 32'h0) begin
      miscompares++;
      $display("FAIL zero_reg_bypass: r0=%h, required 0", a_rd1);
    end
    step();
    idle();
    #1;
    vectors++;
    if (a_rd1 !== 32'h0) begin
      miscompares++;
      $display("FAIL zero_reg_write: r0=%h, required 0", a_rd1);
    end
  endtask

  task automatic test_bypass();
    idle();
    b_we = 1'b1; b_wr = 5'd7; b_wd = 16'h1234;
    step();
    a_we = 1'b1; a_wr = 5'd7; a_wd = 32'hA5A5A5A5; a_rr1 = 5'd7;
    b_we = 1'b1; b_wr = 5'd7; b_wd = 16'hA5A5; b_rr1 = 5'd7;
    #1;
    vectors++;
    if (a_rd1 !== 32'hA5A5A5A5) begin
      miscompares++;
      $display("FAIL bypass_on: got %h, required a5a5a5a5", a_rd1);
    end
    vectors++;
    if (b_rd1 !== 16'h1234) begin
      miscompares++;
      $display("FAIL bypass_off_before: got %h, required 1234", b_rd1);
    end
    step();
    idle();
    #1;
    vectors++;
    if (b_rd1 !== 16'hA5A5) begin
      miscompares++;
      $display("FAIL bypass_off_after: got %h, required a5a5", b_rd1);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    a_rsv = 1'b1; a_rsv_reg = 5'd9; a_rr1 = 5'd9;
    b_rsv = 1'b1; b_rsv_reg = 5'd9; b_rr1 = 5'd9;
    #1;
    vectors++;
    if (a_grant !== 1'b1 || a_rb1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reserve_first: grant=%b busy=%b, required 1/0", a_grant, a_rb1);
    end
    step();
    vectors++;
    if (a_rb1 !== 1'b1 || a_grant !== 1'b0) begin
      miscompares++;
      $display("FAIL reserve_again: busy=%b grant=%b, required 1/0", a_rb1, a_grant);
    end
    idle();
    a_we = 1'b1; a_wr = 5'd9; a_wd = 32'h55;
    b_we = 1'b1; b_wr = 5'd9; b_wd = 16'h55;
    #1;
    vectors++;
    if (a_rb1 !== 1'b0 || a_rd1 !== 32'h55 || b_rb1 !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_clear_same_cycle: a_busy=%b a_data=%h b_busy=%b, required 0/55/1",
               a_rb1, a_rd1, b_rb1);
    end
    step();
    idle();
    #1;
    vectors++;
    if (a_rb1 !== 1'b0 || b_rb1 !== 1'b0 || b_rd1 !== 16'h55) begin
      miscompares++;
      $display("FAIL busy_clear_after: a_busy=%b b_busy=%b b_data=%h, required 0/0/55",
               a_rb1, b_rb1, b_rd1);
    end
    a_rsv = 1'b1; a_rsv_reg = 5'd0; a_rr1 = 5'd0;
    #1;
    vectors++;
    if (a_grant !== 1'b0) begin
      miscompares++;
      $display("FAIL reserve_r0: grant=%b, required 0", a_grant);
    end
    step();
    idle();
    #1;
    vectors++;
    if (a_rb1 !== 1'b0) begin
      miscompares++;
      $display("FAIL r0_busy: got %b, required 0", a_rb1);
    end
  endtask

  task automatic test_simultaneous();
    idle();
    a_we = 1'b1; a_wr = 5'd3; a_wd = 32'h11; a_rsv = 1'b1; a_rsv_reg = 5'd3;
    #1;
    vectors++;
    if (a_grant !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_grant: got %b, required 1", a_grant);
    end
    step();
    idle();
    a_rr1 = 5'd3; a_rr2 = 5'd3;
    #1;
    vectors++;
    if (a_rd1 !== 32'h11 || a_rb1 !== 1'b1 || a_rb2 !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_result: data=%h busy=%b/%b, required 11/1/1", a_rd1, a_rb1, a_rb2);
    end
  endtask

  task automatic test_param_sweep();
    idle();
    b_we = 1'b1; b_wr = 5'd0; b_wd = 16'hBEEF;
    step();
    idle();
    b_rr1 = 5'd0; b_rr2 = 5'd30;
    #1;
    vectors++;
    if (b_rd1 !== 16'hBEEF || b_rd2 !== 16'h0 || b_rb2 !== 1'b0) begin
      miscompares++;
      $display("FAIL sweep_r0_r30: r0=%h r30=%h busy=%b, required beef/0/0", b_rd1, b_rd2, b_rb2);
    end
    b_we = 1'b1; b_wr = 5'd30; b_wd = 16'hFFFF; b_rsv = 1'b1; b_rsv_reg = 5'd30;
    #1;
    vectors++;
    if (b_grant !== 1'b0) begin
      miscompares++;
      $display("FAIL sweep_reserve30: grant=%b, required 0", b_grant);
    end
    step();
    idle();
    #1;
    vectors++;
    if (b_rd2 !== 16'h0 || b_rb2 !== 1'b0) begin
      miscompares++;
      $display("FAIL sweep_after30: data=%h busy=%b, required 0/0", b_rd2, b_rb2);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      a_we = 1'($urandom_range(1)); a_wr = 5'($urandom_range(31)); a_wd = $urandom;
      a_rsv = ($urandom_range(2) != 0);
      a_rsv_reg = ($urandom_range(3) == 0) ? a_wr : 5'($urandom_range(31));
      a_rr1 = ($urandom_range(3) == 0) ? a_wr : 5'($urandom_range(31));
      a_rr2 = 5'($urandom_range(31));
      b_we = 1'($urandom_range(1)); b_wr = 5'($urandom_range(31)); b_wd = 16'($urandom);
      b_rsv = ($urandom_range(2) != 0);
      b_rsv_reg = ($urandom_range(3) == 0) ? b_wr : 5'($urandom_range(31));
      b_rr1 = 5'($urandom_range(31)); b_rr2 = 5'($urandom_range(23));
      #1;
      vectors++;
      if (a_rd1 !== a_exp_data(int'(a_rr1)) || a_rb1 !== a_exp_busy(int'(a_rr1)) ||
          a_rd2 !== a_exp_data(int'(a_rr2)) || a_rb2 !== a_exp_busy(int'(a_rr2)) ||
          a_grant !== a_exp_grant()) begin
        miscompares++;
        $display("FAIL rand_a txn %0d: rd=%h/%h busy=%b%b grant=%b, required %h/%h %b%b %b", n,
                 a_rd1, a_rd2, a_rb1, a_rb2, a_grant,
                 a_exp_data(int'(a_rr1)), a_exp_data(int'(a_rr2)),
                 a_exp_busy(int'(a_rr1)), a_exp_busy(int'(a_rr2)), a_exp_grant());
      end
      vectors++;
      if (b_rd1 !== b_exp_data(int'(b_rr1)) || b_rb1 !== b_exp_busy(int'(b_rr1)) ||
          b_rd2 !== b_exp_data(int'(b_rr2)) || b_rb2 !== b_exp_busy(int'(b_rr2)) ||
          b_grant !== b_exp_grant()) begin
        miscompares++;
        $display("FAIL rand_b txn %0d: rd=%h/%h busy=%b%b grant=%b, required %h/%h %b%b %b", n,
                 b_rd1, b_rd2, b_rb1, b_rb2, b_grant,
                 b_exp_data(int'(b_rr1)), b_exp_data(int'(b_rr2)),
                 b_exp_busy(int'(b_rr1)), b_exp_busy(int'(b_rr2)), b_exp_grant());
      end
      $display("txn %0d: a wr=%0b@%0d rsv=%0b@%0d grant=%0b | b wr=%0b@%0d rsv=%0b@%0d grant=%0b",
               n, a_we, a_wr, a_rsv, a_rsv_reg, a_grant, b_we, b_wr, b_rsv, b_rsv_reg, b_grant);
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    a_rr1 = '0; a_rr2 = '0; b_rr1 = '0; b_rr2 = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_simultaneous();
    test_param_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
